// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath sequencer: instruction field positions,
// legal OP/EXT codes and the FSM state type.
package datapath_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM8_W  = 8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // OP field: 0000 selects register form, anything else is immediate form
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_LSHI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_SUBCI = 4'b1010;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  // EXT field of register-form instructions
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_LSH  = 4'b0100;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_SUBC = 4'b1010;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction-fetch handshake between the fetch stage (master) and the
// datapath sequencer (slave).
interface datapath_sequencer_if;
  import datapath_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/instr_decoder.sv
// Purely combinational decode of the latched instruction into ALU opcode,
// B-mux select, extended immediate, legality and register-write intent.
module instr_decoder
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [FIELD_W-1:0] op,
  input  logic [IMM8_W-1:0]  imm8,
  output logic [7:0]         op_code,
  output logic               use_imm,
  output logic [DATA_W-1:0]  immediate,
  output logic               is_legal,
  output logic               writes_rd
);

  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM8_W-1:0] v,
                                                   input logic zext);
    logic signed [IMM8_W-1:0] v_s;
    v_s = signed'(v);
    if (zext) return DATA_W'(v);
    else      return DATA_W'(v_s);
  endfunction

  logic [FIELD_W-1:0] ext;
  logic               reg_form;
  logic               zext;

  assign ext      = imm8[IMM8_W-1:IMM8_W-FIELD_W];
  assign reg_form = (op == OP_REG);
  // Logical immediates take the byte as an unsigned mask
  assign zext     = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);

  always_comb begin
    op_code   = reg_form ? {4'b0000, ext} : {op, 4'b0000};
    use_imm   = !reg_form;
    immediate = reg_form ? '0 : extend_imm(imm8, zext);
    is_legal  = 1'b0;
    writes_rd = 1'b0;
    if (reg_form) begin
      case (ext)
        EXT_AND, EXT_OR, EXT_XOR, EXT_LSH, EXT_ADD, EXT_ADDU,
        EXT_ADDC, EXT_SUB, EXT_SUBC, EXT_MOV: begin
          is_legal  = 1'b1;
          writes_rd = 1'b1;
        end
        EXT_CMP: is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI, OP_ADDCI,
        OP_LSHI, OP_SUBI, OP_SUBCI, OP_MOVI: begin
          is_legal  = 1'b1;
          writes_rd = 1'b1;
        end
        OP_CMPI: is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Three-state (IDLE/EXEC/WB) sequencer that latches one instruction and drives
// the regfile/ALU controls. Optional macro DATAPATH_SEQ_R0_ZERO_EN hard-wires r0.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  datapath_sequencer_if.slave bus,
  output logic [NUM_REGS-1:0] regEnable,
  output logic [SEL_W-1:0]    a_select,
  output logic [SEL_W-1:0]    b_select,
  output logic                use_imm,
  output logic [DATA_W-1:0]   immediate,
  output logic [7:0]          opCode,
  output logic                done,
  output logic                illegal
);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] ir;
  logic               ready;
  logic               is_legal;
  logic               writes_rd;
  logic               write_ok;
  logic [NUM_REGS-1:0] rd_onehot;

  instr_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .op        (ir[OP_MSB:OP_LSB]),
    .imm8      (ir[IMM_MSB:IMM_LSB]),
    .op_code   (opCode),
    .use_imm   (use_imm),
    .immediate (immediate),
    .is_legal  (is_legal),
    .writes_rd (writes_rd)
  );

  assign a_select  = SEL_W'(ir[RD_MSB:RD_LSB]);
  assign b_select  = SEL_W'(ir[RS_MSB:RS_LSB]);
  assign rd_onehot = NUM_REGS'(1) << ir[RD_MSB:RD_LSB];

`ifdef DATAPATH_SEQ_R0_ZERO_EN
  assign write_ok = writes_rd && (ir[RD_MSB:RD_LSB] != '0);
`else
  assign write_ok = writes_rd;
`endif

  assign bus.instr_ready = ready;

  // Accept stage: IR captures the instruction on the handshake edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && bus.instr_valid) ir <= bus.instr;
    end
  end

  // Controls are decoded from registered state only
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    regEnable  = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_legal) begin
          state_next = S_WB;
        end else begin
          illegal    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WB: begin
        done       = 1'b1;
        state_next = S_IDLE;
        if (write_ok) regEnable = rd_onehot;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
